// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
//
// Read-side companion of the matrix multiplier. On a start pulse it reads the
// dimension header from memory address 1, locates the R x C result matrix that
// follows the A and B operands, and streams the result words out row-major on
// a valid/ready interface with a last-word flag. Port A of the shared memory
// is only ever read.
//
// Memory layout (word addresses, all arithmetic modulo 2^ADDR_WIDTH):
//   1               header: [23:16] R, [15:8] M, [7:0] C
//   2               A, R*M words
//   2+R*M           B, M*C words
//   2+R*M+M*C (RB)  result, R*C words, row-major
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-low
//   start      in   one-cycle pulse; ignored unless idle
//   addr_a     out  memory port A address
//   we_a       out  memory port A write enable (always 0)
//   data_a     in   memory port A read data (one-cycle read latency)
//   out_data   out  stream word
//   out_valid  out  stream word valid
//   out_ready  in   consumer ready; a word moves when valid & ready at an edge
//   out_last   out  marks the final result word
//   busy       out  job in progress
//   done       out  one-cycle pulse at the end of a job
//   dim_error  out  header was illegal; sticky until the next accepted start
// -----------------------------------------------------------------------------
module result_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_LEN    = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  we_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  dim_error
);

  // Word counter width: R*C <= 255*255 always fits, which covers MAX_LEN^2.
  localparam int         CNT_W     = 16;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_WAIT,
    S_HDR_CAP,
    S_CALC,
    S_STREAM,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   dim_error_q;
  logic [7:0]             r_q;
  logic [7:0]             m_q;
  logic [7:0]             c_q;
  logic                   hdr_bad_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       issued_q;

  // ---------------------------------------------------------------------------
  // Read pipeline and output FIFO
  // ---------------------------------------------------------------------------
  // pipe_vld_q marks a read whose data is on data_a this cycle.
  logic                   pipe_vld_q;
  logic                   pipe_last_q;
  // Two-entry FIFO; entry 0 is the head and drives the stream outputs directly,
  // so the head only changes when it is popped (stable under backpressure).
  logic [DATA_WIDTH-1:0]  fifo_data_q [2];
  logic                   fifo_last_q [2];
  logic [1:0]             occ_q;

  logic [DATA_WIDTH-1:0]  fifo_data_d [2];
  logic                   fifo_last_d [2];
  logic [1:0]             occ_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [7:0]             hdr_r;
  logic [7:0]             hdr_m;
  logic [7:0]             hdr_c;
  logic                   hdr_bad_w;
  logic [ADDR_WIDTH-1:0]  rb_w;
  logic [CNT_W-1:0]       count_w;
  logic                   pop;
  logic                   push;
  logic [1:0]             occ_after_pop;
  logic [2:0]             committed;
  logic                   all_issued;
  logic                   issue;
  logic                   stream_end;

  assign hdr_r = data_a[23:16];
  assign hdr_m = data_a[15:8];
  assign hdr_c = data_a[7:0];

  assign hdr_bad_w = (hdr_r == 8'd0) || (hdr_m == 8'd0) || (hdr_c == 8'd0) ||
                     (hdr_r > MAX_LEN_B) || (hdr_m > MAX_LEN_B) ||
                     (hdr_c > MAX_LEN_B);

  // Truncating each product first is exact because the address wraps anyway.
  assign rb_w = ADDR_WIDTH'(2)
              + ADDR_WIDTH'({8'b0, r_q} * {8'b0, m_q})
              + ADDR_WIDTH'({8'b0, m_q} * {8'b0, c_q});

  assign count_w = {8'b0, r_q} * {8'b0, c_q};

  assign pop           = (occ_q != 2'd0) && out_ready;
  assign push          = pipe_vld_q;
  assign occ_after_pop = occ_q - {1'b0, pop};

  // Slots already promised: words left in the FIFO after this edge's pop plus
  // the read whose data lands at this edge. A new read is issued only when a
  // slot remains for it even if nothing is popped next cycle. Counting this
  // edge's pop is what allows one word per cycle with out_ready held high.
  assign committed  = {1'b0, occ_after_pop} + {2'b0, pipe_vld_q};
  assign all_issued = (issued_q == count_q);
  assign issue      = (state_q == S_STREAM) && !all_issued && (committed < 3'd2);

  // Job ends on the edge that pops the final word.
  assign stream_end = (state_q == S_STREAM) && all_issued && !pipe_vld_q &&
                      (occ_after_pop == 2'd0);

  // ---------------------------------------------------------------------------
  // FIFO next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
    end
    // With the credit rule the write slot is always 0 or 1.
    if (push) begin
      fifo_data_d[occ_after_pop[0]] = data_a;
      fifo_last_d[occ_after_pop[0]] = pipe_last_q;
    end
    occ_d = occ_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q       <= 2'd0;
      pipe_vld_q  <= 1'b0;
      pipe_last_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      occ_q       <= occ_d;
      pipe_vld_q  <= issue;
      pipe_last_q <= (issued_q == count_q - CNT_W'(1));
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_last_q[i] <= fifo_last_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Job sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dim_error_q <= 1'b0;
      r_q         <= 8'd0;
      m_q         <= 8'd0;
      c_q         <= 8'd0;
      hdr_bad_q   <= 1'b0;
      count_q     <= '0;
      issued_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q      <= ADDR_WIDTH'(1);
            dim_error_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_HDR_WAIT;
          end
        end

        // Header read is in flight.
        S_HDR_WAIT: begin
          state_q <= S_HDR_CAP;
        end

        // Header word is on data_a: register the fields and their legality
        // so the products in CALC start from registers.
        S_HDR_CAP: begin
          r_q       <= hdr_r;
          m_q       <= hdr_m;
          c_q       <= hdr_c;
          hdr_bad_q <= hdr_bad_w;
          state_q   <= S_CALC;
        end

        // An illegal header ends the job here, so the error flag and the done
        // pulse appear together.
        S_CALC: begin
          if (hdr_bad_q) begin
            dim_error_q <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            addr_q   <= rb_w;
            count_q  <= count_w;
            issued_q <= '0;
            state_q  <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (issue) begin
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            issued_q <= issued_q + CNT_W'(1);
          end
          if (stream_end) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end

        // done is high for this one cycle; the default above clears it.
        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign addr_a    = addr_q;
  assign we_a      = 1'b0;
  assign out_data  = fifo_data_q[0];
  assign out_valid = (occ_q != 2'd0);
  // Gated so a stale flag left in the head slot never shows once drained.
  assign out_last  = out_valid && fifo_last_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign dim_error = dim_error_q;

endmodule
